// File: rtl/recv_handshake.sv
// Receive side of the two-phase REQ/ACK word link: synchronizes RX_REQ, buffers
// words in a first-word-fall-through FIFO and presents them as AXI4-Stream packets.
module recv_handshake #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned PKT_LEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] RX_DATA,
    input  logic        RX_REQ,
    output logic        RX_ACK,
    output logic [15:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic [1:0]  M_AXIS_TKEEP,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic        RECV_DONE,
    output logic        PROTO_ERR
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_req_s1;
    logic          r_req_s2;
    logic          r_req_d;
    logic          w_req_edge;

    logic          r_ack;
    logic          r_done;
    logic          r_proto_err;
    logic [CW-1:0] r_wcnt;
    logic          w_last;

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [16:0]   r_mem [DEPTH];
    logic [16:0]   w_head;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_proto_set;

    // RX_REQ is asynchronous to clk; two flops before any use, then a history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
            r_req_d  <= 1'b0;
        end else begin
            r_req_s1 <= RX_REQ;
            r_req_s2 <= r_req_s1;
            r_req_d  <= r_req_s2;
        end
    end

    assign w_req_edge = r_req_s2 ^ r_req_d;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head  = r_mem[r_rptr[AW-1:0]];
    assign w_rd_en = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_last  = (r_wcnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Full is judged on registered pointers, so a same-cycle read never unblocks a write.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_proto_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_edge) begin
                    if (!w_full) begin
                        w_wr_en = 1'b1;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!w_full) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = IDLE;
                end
                if (w_req_edge) begin
                    w_proto_set = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[AW-1:0]] <= {w_last, RX_DATA};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_wcnt      <= '0;
            r_ack       <= 1'b0;
            r_done      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + (AW+1)'(1);
                r_ack  <= ~r_ack;
                r_wcnt <= w_last ? '0 : r_wcnt + CW'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
            // Completing a packet takes priority over a new word clearing the flag.
            if (w_rd_en && w_head[16]) begin
                r_done <= 1'b1;
            end else if (w_wr_en) begin
                r_done <= 1'b0;
            end
            if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign RX_ACK        = r_ack;
    assign M_AXIS_TVALID = !w_empty;
    assign M_AXIS_TDATA  = w_head[15:0];
    assign M_AXIS_TLAST  = w_head[16] && !w_empty;
    assign M_AXIS_TKEEP  = '1;
    assign RECV_DONE     = r_done;
    assign PROTO_ERR     = r_proto_err;

endmodule
